// File: rtl/clk_lock_detect_pkg.sv
// Shared types and helpers for the clk_lock_detect frequency-window lock detector.
package clk_lock_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } lock_state_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/clk_lock_detect_if.sv
// Monitored-clock input and lock-status outputs of clk_lock_detect.
// With CLK_LOCK_STICKY_LOSS_EN defined, also carries lost_sticky / clr_sticky.
interface clk_lock_detect_if #(
  parameter int unsigned CW = 10
);
  logic          mon_clk;
  logic          locked;
  logic [CW-1:0] edge_cnt_q;
  logic          win_done;
`ifdef CLK_LOCK_STICKY_LOSS_EN
  logic          lost_sticky;
  logic          clr_sticky;

  modport slave  (input  mon_clk, clr_sticky,
                  output locked, edge_cnt_q, win_done, lost_sticky);
  modport master (output mon_clk, clr_sticky,
                  input  locked, edge_cnt_q, win_done, lost_sticky);
`else
  modport slave  (input  mon_clk,
                  output locked, edge_cnt_q, win_done);
  modport master (output mon_clk,
                  input  locked, edge_cnt_q, win_done);
`endif
endinterface

// File: rtl/clk_lock_detect_edge_sync.sv
// 2-FF synchronizer plus a third stage for rising-edge detection of an asynchronous input.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_lock_detect.sv
// Frequency-window lock detector: counts mon_clk rising edges per reference window.
// Optional sticky loss flag enabled by defining CLK_LOCK_STICKY_LOSS_EN.
module clk_lock_detect
  import clk_lock_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned EXP_EDGES     = 250,
  parameter int unsigned TOL           = 2,
  parameter int unsigned LOCK_WINDOWS  = 4
) (
  input logic              clk,
  input logic              rst_n,
  clk_lock_detect_if.slave bus
);

  localparam int unsigned    CW          = cnt_width(WINDOW_CYCLES);
  localparam int unsigned    GW          = cnt_width(LOCK_WINDOWS);
  localparam logic [CW-1:0]  WIN_LAST    = CW'(WINDOW_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX     = '1;
  localparam int unsigned    LO_BOUND    = (TOL > EXP_EDGES) ? 0 : EXP_EDGES - TOL;
  localparam int unsigned    HI_BOUND    = EXP_EDGES + TOL;
  localparam logic [GW-1:0]  GOOD_TARGET = GW'(LOCK_WINDOWS);

  logic          rise;
  logic          closing;
  logic          good;
  logic [CW-1:0] total;

  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0] edge_acc_q, edge_acc_d;
  logic [CW-1:0] edge_out_q;
  logic          win_done_q;
  lock_state_e   state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;

  edge_sync u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.mon_clk),
    .rise_o  (rise)
  );

  // A rise on the closing cycle is folded into this window's total.
  always_comb begin
    closing    = (win_cnt_q == WIN_LAST);
    total      = (rise && (edge_acc_q != CNT_MAX)) ? edge_acc_q + CW'(1) : edge_acc_q;
    good       = (32'(total) >= LO_BOUND) && (32'(total) <= HI_BOUND);
    win_cnt_d  = closing ? '0 : win_cnt_q + CW'(1);
    edge_acc_d = closing ? '0 : total;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    if (closing) begin
      case (state_q)
        ACQUIRE: begin
          if (!good) begin
            good_cnt_d = '0;
          end else if (good_cnt_q + GW'(1) == GOOD_TARGET) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end
        LOCKED: begin
          if (!good) begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
          end
        end
        default: begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      edge_acc_q <= '0;
      edge_out_q <= '0;
      win_done_q <= 1'b0;
      state_q    <= ACQUIRE;
      good_cnt_q <= '0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      edge_acc_q <= edge_acc_d;
      win_done_q <= closing;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      if (closing) begin
        edge_out_q <= total;
      end
    end
  end

  assign bus.locked     = (state_q == LOCKED);
  assign bus.edge_cnt_q = edge_out_q;
  assign bus.win_done   = win_done_q;

`ifdef CLK_LOCK_STICKY_LOSS_EN
  logic lost_sticky_q;
  logic loss_evt;

  assign loss_evt = closing && (state_q == LOCKED) && (state_d == ACQUIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_sticky_q <= 1'b0;
    end else if (loss_evt) begin
      lost_sticky_q <= 1'b1;
    end else if (bus.clr_sticky) begin
      lost_sticky_q <= 1'b0;
    end
  end

  assign bus.lost_sticky = lost_sticky_q;
`endif

endmodule

// File: tb/tb_clk_lock_detect.sv
// Randomized self-checking bench for clk_lock_detect against a window-level reference model.
module tb_clk_lock_detect;
  import clk_lock_pkg::*;

  localparam int unsigned W     = 1000;
  localparam int unsigned EXP   = 250;
  localparam int unsigned TOL   = 2;
  localparam int unsigned LOCKN = 4;
  localparam int unsigned CW    = cnt_width(W);
  localparam int unsigned LO    = (TOL > EXP) ? 0 : EXP - TOL;
  localparam int unsigned HI    = EXP + TOL;
  localparam int unsigned SATV  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clk_lock_detect_if #(.CW(CW)) bus ();

  clk_lock_detect #(
    .WINDOW_CYCLES (W),
    .EXP_EDGES     (EXP),
    .TOL           (TOL),
    .LOCK_WINDOWS  (LOCKN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int unsigned total_cnt = 0;
  int unsigned bad_cnt   = 0;

  int unsigned d;                // driven cycles since reset release
  int unsigned exp_cnt [0:127];  // expected edge count per window
  bit          mon_prev;
  int unsigned streak;           // consecutive good windows
  bit          lock_exp;
  bit          sticky_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, d);
    end
  endtask

  // Called at a negedge; drives one reference cycle and checks after the posedge.
  task automatic cycle(input logic m);
    int unsigned n, k, tot;
    bit          good, prev;
    bit          clr;
    clr = 1'b0;
    bus.mon_clk = m;
    // A rise driven before edge d+1 is counted at edge d+3, i.e. in window (d+2)/W.
    if (m && !mon_prev) exp_cnt[(d + 2) / W]++;
    mon_prev = m;
`ifdef CLK_LOCK_STICKY_LOSS_EN
    clr = ($urandom_range(0, 299) == 0);
    bus.clr_sticky = clr;
`endif
    @(posedge clk);
    #1;
    n = d + 1;
    if (n % W == 0) begin
      k    = n / W;
      tot  = (exp_cnt[k-1] > SATV) ? SATV : exp_cnt[k-1];
      good = (tot >= LO) && (tot <= HI);
      prev = lock_exp;
      streak   = good ? streak + 1 : 0;
      lock_exp = (streak >= LOCKN);
      if (prev && !lock_exp) sticky_exp = 1'b1;
      else if (clr)          sticky_exp = 1'b0;
      check_val("win_done_close", bus.win_done, 1);
      check_val("edge_cnt_q", bus.edge_cnt_q, tot);
    end else begin
      if (clr) sticky_exp = 1'b0;
      check_val("win_done_idle", bus.win_done, 0);
    end
    check_val("locked", bus.locked, lock_exp);
`ifdef CLK_LOCK_STICKY_LOSS_EN
    check_val("lost_sticky", bus.lost_sticky, sticky_exp);
`endif
    d++;
    @(negedge clk);
  endtask

  // N evenly spaced one-cycle pulses, kept clear of the last two cycles of the window.
  task automatic run_window(input int unsigned n_edges, input int unsigned ncyc);
    int unsigned i;
    logic        m;
    i = 0;
    for (int unsigned c = 0; c < ncyc; c++) begin
      m = 1'b0;
      if (n_edges > 0 && i < n_edges && c == (i * (W - 2)) / n_edges) begin
        m = 1'b1;
        i++;
      end
      cycle(m);
    end
  endtask

  // Called at a negedge; asserts reset, checks async response, releases at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_locked", bus.locked, 0);
    check_val("rst_win_done", bus.win_done, 0);
    check_val("rst_edge_cnt_q", bus.edge_cnt_q, 0);
`ifdef CLK_LOCK_STICKY_LOSS_EN
    check_val("rst_lost_sticky", bus.lost_sticky, 0);
`endif
    repeat (3) @(negedge clk);
    bus.mon_clk = 1'b0;
    mon_prev    = 1'b0;
    d           = 0;
    streak      = 0;
    lock_exp    = 1'b0;
    sticky_exp  = 1'b0;
    for (int i = 0; i < 128; i++) exp_cnt[i] = 0;
    rst_n = 1'b1;
  endtask

  int unsigned plan [$] = '{
    250, 250, 250, 250,          // acquire lock
    260,                         // too fast -> loss
    250, 250, 250, 250,
    0,                           // stopped clock -> loss
    248, 252, 248, 252,          // boundaries accepted
    247,                         // just below -> bad
    252, 248, 250, 253,          // just above -> bad after three good
    250, 250, 250, 247,          // three good then bad
    250, 250, 250, 250           // lock only after fourth post-bad good
  };

  initial begin
    rst_n       = 1'b0;
    bus.mon_clk = 1'b0;
`ifdef CLK_LOCK_STICKY_LOSS_EN
    bus.clr_sticky = 1'b0;
`endif
    d = 0;
    @(negedge clk);
    do_reset();

    foreach (plan[i]) run_window(plan[i], W);

    for (int i = 0; i < 8; i++) begin
      int unsigned n_e;
      if ($urandom_range(0, 9) < 7) n_e = $urandom_range(EXP - TOL - 1, EXP + TOL + 1);
      else                          n_e = $urandom_range(0, 300);
      run_window(n_e, W);
    end

    repeat (4) run_window(250, W);
    run_window(250, 300);
    check_val("pre_reset_locked", bus.locked, 1);
    do_reset();
    repeat (5) run_window(250, W);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
